mips_multicycle: RTL and testbench
==================================

Name: mips_multicycle

Overview:
- Parametrised multicycle successor to the team's single-cycle MIPS-style core.
- Fetches one instruction per transaction over a req/valid instruction-memory handshake and sequences FETCH/DECODE/EXECUTE/WRITEBACK through an FSM.
- Adds reset, wait-state tolerance, halt, a hardwired-zero R0 and a debug register read port.
- Sits between an external instruction memory and the surrounding system, which observes retire/halted/pc.

Parameters:
- DATA_W, 64: register and ALU width.
- ADDR_W, 16: PC / instruction address width; also the width of the branch-target field.
- REG_AW, 6: register address width; 2**REG_AW registers.
- INSTR_W, 64: instruction width; must be ≥ 18+max(ADDR_W,16).
- RESET_PC, 0: PC value loaded on reset.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request.
- imem_addr  out  ADDR_W  fetch address (= pc).
- imem_valid  in  1  fetch data valid.
- imem_rdata  in  INSTR_W  fetched instruction.
- retire  out  1  one-cycle pulse per completed instruction.
- halted  out  1  core stopped.
- pc  out  ADDR_W  address of the current instruction.
- dbg_raddr  in  REG_AW  debug register select.
- dbg_rdata  out  DATA_W  combinational read of reg[dbg_raddr]; 0 when dbg_raddr=0.

Behaviour:
- Reset (async, rst_n=0):
  - State FETCH, pc=RESET_PC, all registers 0.
  - imem_req=0, retire=0, halted=0.
  - imem_req rises in the first clock cycle after rst_n deasserts.
- Instruction fields:
  - op=[5:0], rd=[11:6], rs1=[17:12], rs2=[23:18], imm=[33:18] (16 bits, sign-extended to DATA_W), tgt=[18+ADDR_W-1:18].
  - Fields use the low REG_AW bits of each 6-bit slot.
- FETCH:
  - imem_req=1, imem_addr=pc; both are held stable until a rising edge samples imem_valid=1.
  - imem_rdata is latched into the IR on that edge; go to DECODE.
  - imem_valid is ignored when imem_req=0.
- DECODE (1 cycle): read operand A=reg[rs1].
  - Operand B=reg[rd] for BEQ (register-swap mux); otherwise reg[rs2].
  - Register 0 always reads 0.
- EXECUTE (1 cycle): compute the ALU result and the branch condition; latch both.
- WRITEBACK (1 cycle):
  - Write rd if the op writes; writes to R0 are discarded.
  - retire=1 for this cycle only.
  - pc ← tgt if BEQ is taken or the op is JMP; otherwise pc+1, wrapping mod 2**ADDR_W.
  - Next state is FETCH, or HALTED for HALT.
- Latency: 4 cycles per instruction with zero-wait memory (imem_valid=1 in the request cycle); each wait cycle adds 1.
- Opcodes (all arithmetic is modulo 2**DATA_W):
  - 0 NOP: no write.
  - 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR: rd ← rs1 op rs2.
  - 6 SLT: rd ← 1 if rs1 < rs2 signed, else 0.
  - 7 LDI: rd ← sext(imm).
  - 8 BEQ: branch to tgt if reg[rs1]==reg[rd].
  - 9 JMP: pc ← tgt.
  - 63 HALT.
  - All others are illegal (see Optional Feature).
- HALTED:
  - halted=1 and imem_req=0.
  - pc holds the HALT instruction address; no further retire.
  - Only reset exits this state.
- Reset mid-operation: any state aborts immediately. A partially fetched instruction is discarded and no register write occurs.
- dbg_rdata is purely combinational and does not disturb execution.

Optional Feature:
- Macro MIPS_TRAP_EN.
- Defined:
  - Adds output port trap (1 bit, reset 0).
  - An illegal opcode in EXECUTE goes to a TRAP state: no register write, no retire, pc held at the offending address, halted=1, trap=1, imem_req=0.
  - Only reset exits TRAP.
- Undefined: there is no trap port; illegal opcodes execute as NOP (retire pulse, pc+1).

Test Plan:
- Reset: hold rst_n=0 with clk running → imem_req=0, retire=0, halted=0, pc=0. Release → imem_req=1 with imem_addr=0x0000 on the next cycle.
- Zero-wait ALU program: LDI r1,5; LDI r2,-3; ADD r3,r1,r2; SLT r4,r2,r1; SUB r5,r2,r1 →
  - dbg r3=2, r4=1, r5=0xFFFF_FFFF_FFFF_FFF8.
  - 5 retire pulses, one every 4 cycles; pc=5 after the last.
- Wait states: imem_valid held low for 3 request cycles → imem_addr stable throughout, instruction latched exactly once, retire 7 cycles after imem_req first rises.
- Branch/jump:
  - r1=r6=7, BEQ rs1=r1, rd=r6, tgt=0x0040 → next imem_addr=0x0040.
  - Same with r6=8 → pc+1.
  - JMP 0xFFFF then NOP at 0xFFFF → next fetch 0x0000 (wrap).
- R0 and halt:
  - ADD r0,r1,r1 → dbg r0=0.
  - HALT at 0x0010 → retire pulse, halted=1, pc=0x0010, imem_req stays 0 for 20 cycles.
  - Pulse rst_n → fetch restarts at 0x0000.
- Illegal opcode 0x20:
  - With MIPS_TRAP_EN → trap=1, halted=1, no retire, pc unchanged.
  - Without → retire pulse, pc+1, registers unchanged.

Source files
------------

// File: rtl/mips_multicycle.sv
// Multicycle MIPS-style core: FETCH/DECODE/EXECUTE/WRITEBACK over a req/valid instruction fetch.
// Optional macro MIPS_TRAP_EN adds a trap output and a terminal TRAP state for illegal opcodes.
module mips_multicycle #(
  parameter int DATA_W            = 64,
  parameter int ADDR_W            = 16,
  parameter int REG_AW            = 6,
  parameter int INSTR_W           = 64,
  parameter int unsigned RESET_PC = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_valid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               retire,
  output logic               halted,
  output logic [ADDR_W-1:0]  pc,
  input  logic [REG_AW-1:0]  dbg_raddr,
  output logic [DATA_W-1:0]  dbg_rdata
`ifdef MIPS_TRAP_EN
  ,
  output logic               trap
`endif
);

  localparam logic [5:0] OP_ADD  = 6'd1;
  localparam logic [5:0] OP_SUB  = 6'd2;
  localparam logic [5:0] OP_AND  = 6'd3;
  localparam logic [5:0] OP_OR   = 6'd4;
  localparam logic [5:0] OP_XOR  = 6'd5;
  localparam logic [5:0] OP_SLT  = 6'd6;
  localparam logic [5:0] OP_LDI  = 6'd7;
  localparam logic [5:0] OP_BEQ  = 6'd8;
  localparam logic [5:0] OP_JMP  = 6'd9;
  localparam logic [5:0] OP_HALT = 6'd63;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK,
    S_HALTED,
    S_TRAP
  } state_t;

  state_t state, state_nx;

  logic [INSTR_W-1:0] ir;
  logic [DATA_W-1:0]  regs [0:(1<<REG_AW)-1];
  logic [DATA_W-1:0]  opa, opb, result, alu;
  logic               take;

  logic [5:0]         op;
  logic [REG_AW-1:0]  rd, rs1, rs2, rsb;
  logic [15:0]        imm;
  logic [ADDR_W-1:0]  tgt;
  logic               wr_op;
  logic               unused_ir;

  assign op        = ir[5:0];
  assign rd        = ir[6 +: REG_AW];
  assign rs1       = ir[12 +: REG_AW];
  assign rs2       = ir[18 +: REG_AW];
  assign imm       = ir[33:18];
  assign tgt       = ir[18 +: ADDR_W];
  assign unused_ir = ^ir;

  // BEQ compares rs1 against rd, so the second read port is steered to rd for it
  assign rsb   = (op == OP_BEQ) ? rd : rs2;
  assign wr_op = (op >= OP_ADD) && (op <= OP_LDI);

  assign imem_addr = pc;
  assign dbg_rdata = (dbg_raddr == '0) ? '0 : regs[dbg_raddr];

  always_comb begin
    alu = '0;
    case (op)
      OP_ADD: alu = opa + opb;
      OP_SUB: alu = opa - opb;
      OP_AND: alu = opa & opb;
      OP_OR:  alu = opa | opb;
      OP_XOR: alu = opa ^ opb;
      OP_SLT: alu = {{(DATA_W-1){1'b0}}, ($signed(opa) < $signed(opb))};
      OP_LDI: alu = {{(DATA_W-16){imm[15]}}, imm};
      default: alu = '0;
    endcase
  end

`ifdef MIPS_TRAP_EN
  logic legal;
  assign legal = (op <= OP_JMP) || (op == OP_HALT);
  assign trap  = (state == S_TRAP);
`endif

  always_comb begin
    state_nx = state;
    imem_req = 1'b0;
    retire   = 1'b0;
    halted   = 1'b0;
    case (state)
      S_FETCH: begin
        // gated by rst_n so the request stays low while reset is held
        imem_req = rst_n;
        if (imem_valid) state_nx = S_DECODE;
      end
      S_DECODE:  state_nx = S_EXECUTE;
      S_EXECUTE: begin
`ifdef MIPS_TRAP_EN
        state_nx = legal ? S_WRITEBACK : S_TRAP;
`else
        state_nx = S_WRITEBACK;
`endif
      end
      S_WRITEBACK: begin
        retire   = 1'b1;
        state_nx = (op == OP_HALT) ? S_HALTED : S_FETCH;
      end
      S_HALTED: halted = 1'b1;
      S_TRAP:   halted = 1'b1;
      default:  state_nx = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_FETCH;
      pc     <= ADDR_W'(RESET_PC);
      ir     <= '0;
      opa    <= '0;
      opb    <= '0;
      result <= '0;
      take   <= 1'b0;
      for (int i = 0; i < (1 << REG_AW); i++) regs[i] <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_FETCH: if (imem_valid) ir <= imem_rdata;
        S_DECODE: begin
          opa <= (rs1 == '0) ? '0 : regs[rs1];
          opb <= (rsb == '0) ? '0 : regs[rsb];
        end
        S_EXECUTE: begin
          result <= alu;
          take   <= (op == OP_JMP) || ((op == OP_BEQ) && (opa == opb));
        end
        S_WRITEBACK: begin
          if (wr_op && (rd != '0)) regs[rd] <= result;
          // HALT leaves pc on its own address
          if (op != OP_HALT) pc <= take ? tgt : pc + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle.sv
// Self-checking bench for mips_multicycle: directed programs plus random programs
// compared against an instruction-level reference model of the core.
`timescale 1ns/1ps
module tb_mips_multicycle;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_valid = 1'b0;
  logic [63:0] imem_rdata = '0;
  logic        retire;
  logic        halted;
  logic [15:0] pc;
  logic [5:0]  dbg_raddr = '0;
  logic [63:0] dbg_rdata;
`ifdef MIPS_TRAP_EN
  logic        trap;
`endif

  int nCompared = 0;
  int nMismatched = 0;

  mips_multicycle dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .retire(retire), .halted(halted), .pc(pc),
    .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
`ifdef MIPS_TRAP_EN
    , .trap(trap)
`endif
  );

  always #5 clk = ~clk;

  // instruction memory image and responder with configurable wait states
  logic [63:0] mem [int unsigned];
  int waitCfg = 0, curWait = 0, reqCycles = 0;
  bit randWait = 0, noise = 0;

  function automatic logic [63:0] memAt(logic [15:0] a);
    return mem.exists(int'(a)) ? mem[int'(a)] : 64'h0;
  endfunction

  always @(negedge clk) begin
    if (imem_req) begin
      if (reqCycles == 0) curWait = randWait ? int'($urandom_range(0, 2)) : waitCfg;
      imem_valid = (reqCycles >= curWait);
      imem_rdata = imem_valid ? memAt(imem_addr) : {$urandom, $urandom};
      reqCycles++;
    end else begin
      reqCycles  = 0;
      imem_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      imem_rdata = {$urandom, $urandom};
    end
  end

  function automatic logic [63:0] encR(logic [5:0] op, logic [5:0] rd, logic [5:0] rs1, logic [5:0] rs2);
    return {40'h0, rs2, rs1, rd, op};
  endfunction

  function automatic logic [63:0] encI(logic [5:0] op, logic [5:0] rd, logic [5:0] rs1, logic [15:0] imm);
    return {30'h0, imm, rs1, rd, op};
  endfunction

  // instruction-level reference model
  logic [63:0] mregs [64];
  logic [15:0] mpc;
  bit          mhalted, mtrap;

  task automatic modelReset();
    for (int i = 0; i < 64; i++) mregs[i] = '0;
    mpc = '0; mhalted = 0; mtrap = 0;
  endtask

  task automatic modelStep();
    logic [63:0] ins, a, b, d, v;
    logic [5:0]  op, rd, rs1, rs2;
    logic [15:0] imm;
    bit wr;
    ins = memAt(mpc);
    op = ins[5:0]; rd = ins[11:6]; rs1 = ins[17:12]; rs2 = ins[23:18]; imm = ins[33:18];
    a = mregs[rs1]; b = mregs[rs2]; d = mregs[rd]; v = '0; wr = 1;
    case (op)
      1: v = a + b;
      2: v = a - b;
      3: v = a & b;
      4: v = a | b;
      5: v = a ^ b;
      6: v = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      7: v = {{48{imm[15]}}, imm};
      default: wr = 0;
    endcase
    if (wr && rd != 0) mregs[rd] = v;
    if (op == 63) mhalted = 1;
    else if (op == 9 || (op == 8 && a == d)) mpc = imm;
    else if (op > 9) begin
`ifdef MIPS_TRAP_EN
      mtrap = 1; mhalted = 1;
`else
      mpc = mpc + 16'd1;
`endif
    end else mpc = mpc + 16'd1;
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic startProgram();
    rst_n = 1'b0;
    repeat (2) tick();
    @(posedge clk);
    #1 rst_n = 1'b1;
    modelReset();
  endtask

  // waits for the next retire pulse, recording fetch behaviour on the way
  task automatic waitRetire(input int bound, output int cycles, output bit seen,
                            output logic [15:0] addr0, output int latches, output bit stable);
    bit gotAddr;
    gotAddr = 0; cycles = 0; seen = 0; latches = 0; stable = 1; addr0 = 'x;
    while (cycles < bound && !seen) begin
      tick();
      cycles++;
      if (imem_req === 1'b1) begin
        if (!gotAddr) begin addr0 = imem_addr; gotAddr = 1; end
        else if (imem_addr !== addr0) stable = 0;
        if (imem_valid) latches++;
      end
      if (retire === 1'b1) seen = 1;
    end
  endtask

  task automatic test_reset();
    mem.delete();
    mem[0] = encI(6'd7, 6'd1, 6'd0, 16'h0011);
    waitCfg = 0; randWait = 0; noise = 1;
    rst_n = 1'b0;
    repeat (3) tick();
    nCompared++; if (imem_req !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_req: got %b expected 0", imem_req); end
    nCompared++; if (retire !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_retire: got %b expected 0", retire); end
    nCompared++; if (halted !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_halted: got %b expected 0", halted); end
    nCompared++; if (pc !== 16'h0) begin nMismatched++; $display("[TB] FAIL reset_pc: got %h expected 0000", pc); end
`ifdef MIPS_TRAP_EN
    nCompared++; if (trap !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_trap: got %b expected 0", trap); end
`endif
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    nCompared++; if (imem_req !== 1'b1) begin nMismatched++; $display("[TB] FAIL release_req: got %b expected 1", imem_req); end
    nCompared++; if (imem_addr !== 16'h0) begin nMismatched++; $display("[TB] FAIL release_addr: got %h expected 0000", imem_addr); end
  endtask

  task automatic test_alu_program();
    int cyc, lat; bit seen, stab; logic [15:0] a0;
    logic [63:0] expR [3];
    mem.delete();
    mem[0] = encI(6'd7, 6'd1, 6'd0, 16'd5);
    mem[1] = encI(6'd7, 6'd2, 6'd0, 16'hFFFD);
    mem[2] = encR(6'd1, 6'd3, 6'd1, 6'd2);
    mem[3] = encR(6'd6, 6'd4, 6'd2, 6'd1);
    mem[4] = encR(6'd2, 6'd5, 6'd2, 6'd1);
    mem[5] = encI(6'd63, 6'd0, 6'd0, 16'd0);
    waitCfg = 0; noise = 0;
    startProgram();
    for (int i = 0; i < 5; i++) begin
      waitRetire(20, cyc, seen, a0, lat, stab);
      nCompared++; if (!seen || cyc != 4) begin nMismatched++; $display("[TB] FAIL alu_retire_gap[%0d]: got seen=%0b cycles=%0d expected 4", i, seen, cyc); end
      nCompared++; if (pc !== mpc) begin nMismatched++; $display("[TB] FAIL alu_pc[%0d]: got %h expected %h", i, pc, mpc); end
      modelStep();
    end
    tick();
    nCompared++; if (pc !== 16'd5) begin nMismatched++; $display("[TB] FAIL alu_final_pc: got %h expected 0005", pc); end
    expR[0] = 64'd2; expR[1] = 64'd1; expR[2] = 64'hFFFF_FFFF_FFFF_FFF8;
    for (int r = 3; r <= 5; r++) begin
      dbg_raddr = 6'(r); #1;
      nCompared++; if (dbg_rdata !== expR[r-3] || dbg_rdata !== mregs[r]) begin nMismatched++; $display("[TB] FAIL alu_reg r%0d: got %h expected %h", r, dbg_rdata, expR[r-3]); end
    end
  endtask

  task automatic test_wait_states();
    int cyc, lat; bit seen, stab; logic [15:0] a0;
    mem.delete();
    mem[0] = encI(6'd7, 6'd7, 6'd0, 16'h1234);
    waitCfg = 3; noise = 1;
    startProgram();
    waitRetire(30, cyc, seen, a0, lat, stab);
    nCompared++; if (!seen || cyc != 7) begin nMismatched++; $display("[TB] FAIL wait_latency: got seen=%0b cycles=%0d expected 7", seen, cyc); end
    nCompared++; if (lat != 1) begin nMismatched++; $display("[TB] FAIL wait_latch_count: got %0d expected 1", lat); end
    nCompared++; if (!stab || a0 !== 16'h0) begin nMismatched++; $display("[TB] FAIL wait_addr_stable: got stable=%0b addr=%h expected 1/0000", stab, a0); end
    tick();
    dbg_raddr = 6'd7; #1;
    nCompared++; if (dbg_rdata !== 64'h1234) begin nMismatched++; $display("[TB] FAIL wait_r7: got %h expected 1234", dbg_rdata); end
    waitCfg = 0;
  endtask

  task automatic test_branch_jump();
    int cyc, lat; bit seen, stab; logic [15:0] a0;
    logic [15:0] expAddr [7];
    mem.delete();
    mem[0]       = encI(6'd7, 6'd1, 6'd0, 16'd7);
    mem[1]       = encI(6'd7, 6'd6, 6'd0, 16'd7);
    mem[2]       = encI(6'd8, 6'd6, 6'd1, 16'h0040);
    mem[16'h40]  = encI(6'd7, 6'd6, 6'd0, 16'd8);
    mem[16'h41]  = encI(6'd8, 6'd6, 6'd1, 16'h0080);
    mem[16'h42]  = encI(6'd9, 6'd0, 6'd0, 16'hFFFF);
    mem[16'hFFFF] = 64'h0;
    expAddr[0] = 16'h0000; expAddr[1] = 16'h0001; expAddr[2] = 16'h0002; expAddr[3] = 16'h0040;
    expAddr[4] = 16'h0041; expAddr[5] = 16'h0042; expAddr[6] = 16'hFFFF;
    startProgram();
    for (int i = 0; i < 7; i++) begin
      waitRetire(20, cyc, seen, a0, lat, stab);
      nCompared++; if (!seen || a0 !== expAddr[i] || pc !== expAddr[i]) begin nMismatched++; $display("[TB] FAIL branch_addr[%0d]: got seen=%0b fetch=%h pc=%h expected %h", i, seen, a0, pc, expAddr[i]); end
      modelStep();
    end
    tick();
    nCompared++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin nMismatched++; $display("[TB] FAIL jump_wrap: got req=%b addr=%h expected 1/0000", imem_req, imem_addr); end
  endtask

  task automatic test_r0_halt();
    int cyc, lat, reqs, rets; bit seen, stab; logic [15:0] a0;
    mem.delete();
    mem[0]      = encI(6'd7, 6'd1, 6'd0, 16'd9);
    mem[1]      = encR(6'd1, 6'd0, 6'd1, 6'd1);
    mem[2]      = encR(6'd1, 6'd2, 6'd0, 6'd1);
    mem[3]      = encI(6'd9, 6'd0, 6'd0, 16'h0010);
    mem[16'h10] = encI(6'd63, 6'd0, 6'd0, 16'd0);
    startProgram();
    for (int i = 0; i < 5; i++) begin
      waitRetire(20, cyc, seen, a0, lat, stab);
      nCompared++; if (!seen || pc !== mpc) begin nMismatched++; $display("[TB] FAIL r0_step[%0d]: got seen=%0b pc=%h expected %h", i, seen, pc, mpc); end
      modelStep();
    end
    tick();
    nCompared++; if (halted !== 1'b1 || pc !== 16'h0010) begin nMismatched++; $display("[TB] FAIL halt_state: got halted=%b pc=%h expected 1/0010", halted, pc); end
    dbg_raddr = 6'd0; #1;
    nCompared++; if (dbg_rdata !== 64'h0) begin nMismatched++; $display("[TB] FAIL r0_read: got %h expected 0", dbg_rdata); end
    dbg_raddr = 6'd2; #1;
    nCompared++; if (dbg_rdata !== 64'd9) begin nMismatched++; $display("[TB] FAIL r0_source: got %h expected 9", dbg_rdata); end
    reqs = 0; rets = 0;
    repeat (20) begin tick(); if (imem_req) reqs++; if (retire) rets++; end
    nCompared++; if (reqs != 0 || rets != 0 || halted !== 1'b1) begin nMismatched++; $display("[TB] FAIL halt_hold: got reqs=%0d retires=%0d halted=%b expected 0/0/1", reqs, rets, halted); end
    startProgram();
    tick();
    nCompared++; if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0) begin nMismatched++; $display("[TB] FAIL halt_restart: got halted=%b req=%b addr=%h expected 0/1/0000", halted, imem_req, imem_addr); end
  endtask

  task automatic test_mid_reset();
    int cyc, lat; bit seen, stab; logic [15:0] a0;
    mem.delete();
    mem[0] = encI(6'd7, 6'd1, 6'd0, 16'h0077);
    mem[1] = encI(6'd7, 6'd2, 6'd0, 16'h0099);
    mem[2] = encI(6'd63, 6'd0, 6'd0, 16'd0);
    startProgram();
    waitRetire(20, cyc, seen, a0, lat, stab);
    tick(); tick();
    rst_n = 1'b0; #1;
    dbg_raddr = 6'd1; #1;
    nCompared++; if (dbg_rdata !== 64'h0 || pc !== 16'h0 || imem_req !== 1'b0) begin nMismatched++; $display("[TB] FAIL midreset_clear: got r1=%h pc=%h req=%b expected 0/0000/0", dbg_rdata, pc, imem_req); end
    repeat (2) tick();
    @(posedge clk);
    #1 rst_n = 1'b1;
    modelReset();
    waitRetire(20, cyc, seen, a0, lat, stab);
    tick();
    dbg_raddr = 6'd2; #1;
    nCompared++; if (!seen || a0 !== 16'h0 || dbg_rdata !== 64'h0) begin nMismatched++; $display("[TB] FAIL midreset_restart: got seen=%0b fetch=%h r2=%h expected 1/0000/0", seen, a0, dbg_rdata); end
  endtask

  task automatic test_illegal();
    int cyc, lat; bit seen, stab; logic [15:0] a0;
    mem.delete();
    mem[0] = encI(6'd7, 6'd3, 6'd0, 16'h0055);
    mem[1] = encR(6'h20, 6'd3, 6'd3, 6'd3);
    mem[2] = 64'h0;
    mem[3] = encI(6'd63, 6'd0, 6'd0, 16'd0);
    startProgram();
    waitRetire(20, cyc, seen, a0, lat, stab);
    modelStep();
    waitRetire(20, cyc, seen, a0, lat, stab);
`ifdef MIPS_TRAP_EN
    modelStep();
    nCompared++; if (seen || trap !== 1'b1 || halted !== 1'b1 || pc !== 16'd1 || imem_req !== 1'b0) begin nMismatched++; $display("[TB] FAIL illegal_trap: got retire=%0b trap=%b halted=%b pc=%h req=%b expected 0/1/1/0001/0", seen, trap, halted, pc, imem_req); end
    nCompared++; if (mtrap != 1'b1 || mpc !== pc) begin nMismatched++; $display("[TB] FAIL illegal_model_pc: got pc=%h expected %h", pc, mpc); end
`else
    nCompared++; if (!seen || pc !== 16'd1) begin nMismatched++; $display("[TB] FAIL illegal_retire: got seen=%0b pc=%h expected 1/0001", seen, pc); end
    modelStep();
    waitRetire(20, cyc, seen, a0, lat, stab);
    nCompared++; if (!seen || pc !== 16'd2 || pc !== mpc) begin nMismatched++; $display("[TB] FAIL illegal_next_pc: got seen=%0b pc=%h expected 0002", seen, pc); end
`endif
    dbg_raddr = 6'd3; #1;
    nCompared++; if (dbg_rdata !== 64'h55) begin nMismatched++; $display("[TB] FAIL illegal_reg: got %h expected 55", dbg_rdata); end
  endtask

  task automatic test_random();
    int cyc, lat; bit seen, stab; logic [15:0] a0;
    logic [63:0] ins;
    logic [5:0]  op;
    randWait = 1; noise = 1;
    for (int prog = 0; prog < 4; prog++) begin
      mem.delete();
      for (int a = 0; a < 64; a++) begin
        ins = {$urandom, $urandom};
        op  = ($urandom_range(0, 99) < 4) ? 6'd63 : 6'($urandom_range(0, 9));
        if (a < 6) op = 6'd7;
        ins[5:0]   = op;
        ins[11:6]  = 6'($urandom_range(0, 7));
        ins[17:12] = 6'($urandom_range(0, 7));
        ins[23:18] = 6'($urandom_range(0, 7));
        if (op == 6'd8 || op == 6'd9) ins[33:18] = 16'($urandom_range(0, 63));
        mem[a] = ins;
      end
      startProgram();
      for (int s = 0; s < 40 && !mhalted; s++) begin
        waitRetire(20, cyc, seen, a0, lat, stab);
        nCompared++; if (!seen || pc !== mpc || a0 !== mpc) begin nMismatched++; $display("[TB] FAIL rand_step[%0d.%0d]: got seen=%0b pc=%h fetch=%h expected %h", prog, s, seen, pc, a0, mpc); end
        modelStep();
      end
      tick();
      for (int r = 0; r < 8; r++) begin
        dbg_raddr = 6'(r); #1;
        nCompared++; if (dbg_rdata !== mregs[r]) begin nMismatched++; $display("[TB] FAIL rand_reg[%0d] r%0d: got %h expected %h", prog, r, dbg_rdata, mregs[r]); end
      end
      if (mhalted) begin
        nCompared++; if (halted !== 1'b1 || pc !== mpc) begin nMismatched++; $display("[TB] FAIL rand_halt[%0d]: got halted=%b pc=%h expected 1/%h", prog, halted, pc, mpc); end
      end
    end
    randWait = 0; noise = 0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_alu_program();
    test_wait_states();
    test_branch_jump();
    test_r0_halt();
    test_mid_reset();
    test_illegal();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
